// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline bus: ID-side operands/control, WB write port, hazard inputs, EX-side registered outputs.
// master drives the ID/WB/hazard side; slave is the pipeline register itself.
interface id_ex_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned CNT_W  = 16
);
    logic              valid_id;
    logic [DATA_W-1:0] pc_id;
    logic [DATA_W-1:0] imm_id;
    logic [CTRL_W-1:0] ctrl_id;
    logic              RegWrite_id;
    logic              MemRead_id;
    logic [REG_AW-1:0] regfile_write_num_id;
    logic [REG_AW-1:0] regfile_read_num1_id;
    logic [REG_AW-1:0] regfile_read_num2_id;
    logic              uses_rs_id;
    logic              uses_rt_id;
    logic [DATA_W-1:0] regfile_read_data1_id;
    logic [DATA_W-1:0] regfile_read_data2_id;
    logic              RegWrite_mem_wb;
    logic [REG_AW-1:0] regfile_write_num_mem_wb;
    logic [DATA_W-1:0] regfile_write_data_wb;
    logic              mem_busy;
    logic              flush_ex;

    logic              valid_id_ex;
    logic [DATA_W-1:0] pc_id_ex;
    logic [DATA_W-1:0] imm_id_ex;
    logic [CTRL_W-1:0] ctrl_id_ex;
    logic              RegWrite_id_ex;
    logic              MemRead_id_ex;
    logic [REG_AW-1:0] regfile_write_num_id_ex;
    logic [REG_AW-1:0] regfile_read_num1_id_ex;
    logic [REG_AW-1:0] regfile_read_num2_id_ex;
    logic [DATA_W-1:0] regfile_read_data1_id_ex;
    logic [DATA_W-1:0] regfile_read_data2_id_ex;
    logic              stall_if_id;
    logic [CNT_W-1:0]  luse_cnt;

    modport master (
        output valid_id, pc_id, imm_id, ctrl_id, RegWrite_id, MemRead_id,
               regfile_write_num_id, regfile_read_num1_id, regfile_read_num2_id,
               uses_rs_id, uses_rt_id, regfile_read_data1_id, regfile_read_data2_id,
               RegWrite_mem_wb, regfile_write_num_mem_wb, regfile_write_data_wb,
               mem_busy, flush_ex,
        input  valid_id_ex, pc_id_ex, imm_id_ex, ctrl_id_ex, RegWrite_id_ex, MemRead_id_ex,
               regfile_write_num_id_ex, regfile_read_num1_id_ex, regfile_read_num2_id_ex,
               regfile_read_data1_id_ex, regfile_read_data2_id_ex, stall_if_id, luse_cnt
    );

    modport slave (
        input  valid_id, pc_id, imm_id, ctrl_id, RegWrite_id, MemRead_id,
               regfile_write_num_id, regfile_read_num1_id, regfile_read_num2_id,
               uses_rs_id, uses_rt_id, regfile_read_data1_id, regfile_read_data2_id,
               RegWrite_mem_wb, regfile_write_num_mem_wb, regfile_write_data_wb,
               mem_busy, flush_ex,
        output valid_id_ex, pc_id_ex, imm_id_ex, ctrl_id_ex, RegWrite_id_ex, MemRead_id_ex,
               regfile_write_num_id_ex, regfile_read_num1_id_ex, regfile_read_num2_id_ex,
               regfile_read_data1_id_ex, regfile_read_data2_id_ex, stall_if_id, luse_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use interlock, memory-busy hold and branch flush.
// Optional macro IDEX_WB_FWD_EN: capture forwards the same-cycle WB write into the operand registers.
module id_ex_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input logic         clk,
    input logic         rst_n,
    id_ex_pipe_if.slave bus
);

    logic              rs_hit_c;
    logic              rt_hit_c;
    logic              load_use_c;
    logic              bubble_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        rs_hit_c   = bus.uses_rs_id && (bus.regfile_read_num1_id == bus.regfile_write_num_id_ex);
        rt_hit_c   = bus.uses_rt_id && (bus.regfile_read_num2_id == bus.regfile_write_num_id_ex);
        load_use_c = bus.valid_id_ex && bus.MemRead_id_ex &&
                     (bus.regfile_write_num_id_ex != '0) &&
                     bus.valid_id && (rs_hit_c || rt_hit_c);
        bubble_c   = bus.flush_ex || (!bus.mem_busy && load_use_c);
    end

    // Flush wins over stall: upstream squashes its own state anyway
    assign bus.stall_if_id = rst_n && !bus.flush_ex && (bus.mem_busy || load_use_c);

    always_comb begin
        rd1_c = bus.regfile_read_data1_id;
        rd2_c = bus.regfile_read_data2_id;
`ifdef IDEX_WB_FWD_EN
        // Regfile is written and read in the same cycle; take the WB value directly
        if (bus.RegWrite_mem_wb && (bus.regfile_write_num_mem_wb != '0)) begin
            if (bus.regfile_write_num_mem_wb == bus.regfile_read_num1_id) rd1_c = bus.regfile_write_data_wb;
            if (bus.regfile_write_num_mem_wb == bus.regfile_read_num2_id) rd2_c = bus.regfile_write_data_wb;
        end
`endif
    end

`ifdef IDEX_WB_FWD_EN
`else
    logic unused_wb;
    assign unused_wb = ^{bus.RegWrite_mem_wb, bus.regfile_write_num_mem_wb, bus.regfile_write_data_wb};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_id_ex              <= 1'b0;
            bus.pc_id_ex                 <= '0;
            bus.imm_id_ex                <= '0;
            bus.ctrl_id_ex               <= '0;
            bus.RegWrite_id_ex           <= 1'b0;
            bus.MemRead_id_ex            <= 1'b0;
            bus.regfile_write_num_id_ex  <= '0;
            bus.regfile_read_num1_id_ex  <= '0;
            bus.regfile_read_num2_id_ex  <= '0;
            bus.regfile_read_data1_id_ex <= '0;
            bus.regfile_read_data2_id_ex <= '0;
        end else if (bubble_c) begin
            bus.valid_id_ex              <= 1'b0;
            bus.pc_id_ex                 <= '0;
            bus.imm_id_ex                <= '0;
            bus.ctrl_id_ex               <= '0;
            bus.RegWrite_id_ex           <= 1'b0;
            bus.MemRead_id_ex            <= 1'b0;
            bus.regfile_write_num_id_ex  <= '0;
            bus.regfile_read_num1_id_ex  <= '0;
            bus.regfile_read_num2_id_ex  <= '0;
            bus.regfile_read_data1_id_ex <= '0;
            bus.regfile_read_data2_id_ex <= '0;
        end else if (!bus.mem_busy) begin
            bus.valid_id_ex              <= bus.valid_id;
            bus.pc_id_ex                 <= bus.pc_id;
            bus.imm_id_ex                <= bus.imm_id;
            bus.ctrl_id_ex               <= bus.ctrl_id;
            bus.RegWrite_id_ex           <= bus.RegWrite_id;
            bus.MemRead_id_ex            <= bus.MemRead_id;
            bus.regfile_write_num_id_ex  <= bus.regfile_write_num_id;
            bus.regfile_read_num1_id_ex  <= bus.regfile_read_num1_id;
            bus.regfile_read_num2_id_ex  <= bus.regfile_read_num2_id;
            bus.regfile_read_data1_id_ex <= rd1_c;
            bus.regfile_read_data2_id_ex <= rd2_c;
        end
    end

    // Saturating count of load-use bubbles actually inserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.luse_cnt <= '0;
        end else if (!bus.flush_ex && !bus.mem_busy && load_use_c && (bus.luse_cnt != '1)) begin
            bus.luse_cnt <= bus.luse_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe; counter width reduced so saturation is reachable in a short run.
module tb_id_ex_pipe;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SAT   = 255;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;
    logic [63:0] exp_fwd;

    id_ex_pipe_if #(.CNT_W(CNT_W)) bus ();
    id_ex_pipe #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // imm and ctrl are derived from pc so every instruction carries distinct values
    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                            input logic urt, input logic rw, input logic mr,
                            input logic [31:0] d1, input logic [31:0] d2);
        bus.valid_id              = v;
        bus.pc_id                 = pc;
        bus.imm_id                = ~pc;
        bus.ctrl_id               = pc[11:0] ^ 12'h5A5;
        bus.regfile_write_num_id  = rd;
        bus.regfile_read_num1_id  = rs;
        bus.regfile_read_num2_id  = rt;
        bus.uses_rs_id            = urs;
        bus.uses_rt_id            = urt;
        bus.RegWrite_id           = rw;
        bus.MemRead_id            = mr;
        bus.regfile_read_data1_id = d1;
        bus.regfile_read_data2_id = d2;
    endtask

    initial begin
`ifdef IDEX_WB_FWD_EN
        exp_fwd = 64'hDEADBEEF;
`else
        exp_fwd = 64'h0;
`endif
        rst_n = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.RegWrite_mem_wb = 0; bus.regfile_write_num_mem_wb = 0; bus.regfile_write_data_wb = 0;
        bus.flush_ex = 0;
        bus.mem_busy = 1;
        #3;
        chk("rst_valid", 64'(bus.valid_id_ex), 64'h0);
        chk("rst_pc", 64'(bus.pc_id_ex), 64'h0);
        chk("rst_cnt", 64'(bus.luse_cnt), 64'h0);
        chk("rst_stall", 64'(bus.stall_if_id), 64'h0);
        bus.mem_busy = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // lw $8 then dependent add on rs
        drive_id(1, 32'h100, 8, 1, 0, 1, 0, 1, 1, 32'h11, 32'h22);
        tick();
        chk("cap_valid", 64'(bus.valid_id_ex), 64'h1);
        chk("cap_pc", 64'(bus.pc_id_ex), 64'h100);
        chk("cap_imm", 64'(bus.imm_id_ex), 64'hFFFFFEFF);
        chk("cap_ctrl", 64'(bus.ctrl_id_ex), 64'h4A5);
        chk("cap_mr", 64'(bus.MemRead_id_ex), 64'h1);
        chk("cap_rw", 64'(bus.RegWrite_id_ex), 64'h1);
        chk("cap_wn", 64'(bus.regfile_write_num_id_ex), 64'h8);
        chk("cap_rn1", 64'(bus.regfile_read_num1_id_ex), 64'h1);
        chk("cap_d1", 64'(bus.regfile_read_data1_id_ex), 64'h11);
        chk("cap_d2", 64'(bus.regfile_read_data2_id_ex), 64'h22);
        drive_id(1, 32'h104, 9, 8, 2, 1, 1, 1, 0, 32'h33, 32'h44);
        #1 chk("lu_stall", 64'(bus.stall_if_id), 64'h1);
        tick(); exp_cnt++;
        chk("lu_bub_valid", 64'(bus.valid_id_ex), 64'h0);
        chk("lu_bub_mr", 64'(bus.MemRead_id_ex), 64'h0);
        chk("lu_bub_rw", 64'(bus.RegWrite_id_ex), 64'h0);
        chk("lu_bub_ctrl", 64'(bus.ctrl_id_ex), 64'h0);
        chk("lu_bub_wn", 64'(bus.regfile_write_num_id_ex), 64'h0);
        chk("lu_cnt1", 64'(bus.luse_cnt), 64'(exp_cnt));
        #1 chk("lu_stall_drop", 64'(bus.stall_if_id), 64'h0);
        tick();
        chk("lu_after_pc", 64'(bus.pc_id_ex), 64'h104);
        chk("lu_after_valid", 64'(bus.valid_id_ex), 64'h1);
        chk("lu_after_d1", 64'(bus.regfile_read_data1_id_ex), 64'h33);
        chk("lu_after_wn", 64'(bus.regfile_write_num_id_ex), 64'h9);

        // load to $0 never interlocks
        drive_id(1, 32'h108, 0, 3, 0, 1, 0, 1, 1, 0, 0);
        tick();
        drive_id(1, 32'h10C, 9, 0, 0, 1, 1, 1, 0, 32'h5, 32'h6);
        #1 chk("r0_stall", 64'(bus.stall_if_id), 64'h0);
        tick();
        chk("r0_pc", 64'(bus.pc_id_ex), 64'h10C);
        chk("r0_cnt", 64'(bus.luse_cnt), 64'(exp_cnt));

        // rs matches but is not used
        drive_id(1, 32'h110, 8, 3, 0, 1, 0, 1, 1, 0, 0);
        tick();
        drive_id(1, 32'h114, 9, 8, 3, 0, 0, 1, 0, 32'h7, 32'h7);
        #1 chk("nouse_stall", 64'(bus.stall_if_id), 64'h0);
        tick();
        chk("nouse_pc", 64'(bus.pc_id_ex), 64'h114);
        chk("nouse_cnt", 64'(bus.luse_cnt), 64'(exp_cnt));

        // rt dependency
        drive_id(1, 32'h118, 8, 3, 0, 1, 0, 1, 1, 0, 0);
        tick();
        drive_id(1, 32'h11C, 9, 1, 8, 1, 1, 1, 0, 0, 0);
        #1 chk("rt_stall", 64'(bus.stall_if_id), 64'h1);
        tick(); exp_cnt++;
        chk("rt_valid", 64'(bus.valid_id_ex), 64'h0);
        chk("rt_cnt", 64'(bus.luse_cnt), 64'(exp_cnt));
        tick();
        chk("rt_pc", 64'(bus.pc_id_ex), 64'h11C);

        // invalid ID instruction does not interlock
        drive_id(1, 32'h120, 8, 3, 0, 1, 0, 1, 1, 0, 0);
        tick();
        drive_id(0, 32'h124, 9, 8, 0, 1, 0, 1, 0, 0, 0);
        #1 chk("inv_stall", 64'(bus.stall_if_id), 64'h0);
        tick();
        chk("inv_valid", 64'(bus.valid_id_ex), 64'h0);
        chk("inv_pc", 64'(bus.pc_id_ex), 64'h124);

        // mem_busy hold for three cycles with changing ID inputs
        drive_id(1, 32'h200, 10, 1, 2, 1, 1, 1, 0, 32'h1234, 32'h5678);
        tick();
        chk("busy_pre_d1", 64'(bus.regfile_read_data1_id_ex), 64'h1234);
        for (int i = 0; i < 3; i++) begin
            drive_id(1, 32'h300 + 32'(i * 4), 11, 3, 4, 1, 1, 1, 0, 32'h9000 + 32'(i), 32'h0);
            bus.mem_busy = 1;
            #1 chk("busy_stall", 64'(bus.stall_if_id), 64'h1);
            tick();
            chk("busy_d1", 64'(bus.regfile_read_data1_id_ex), 64'h1234);
            chk("busy_pc", 64'(bus.pc_id_ex), 64'h200);
        end
        bus.mem_busy = 0;
        #1 chk("busy_rel_stall", 64'(bus.stall_if_id), 64'h0);
        tick();
        chk("busy_rel_pc", 64'(bus.pc_id_ex), 64'h308);
        chk("busy_rel_d1", 64'(bus.regfile_read_data1_id_ex), 64'h9002);

        // load-use while busy: hold only, bubble after busy drops
        drive_id(1, 32'h400, 8, 3, 0, 1, 0, 1, 1, 0, 0);
        tick();
        drive_id(1, 32'h404, 9, 8, 0, 1, 0, 1, 0, 0, 0);
        bus.mem_busy = 1;
        #1 chk("lub_stall", 64'(bus.stall_if_id), 64'h1);
        tick();
        chk("lub_hold_valid", 64'(bus.valid_id_ex), 64'h1);
        chk("lub_hold_mr", 64'(bus.MemRead_id_ex), 64'h1);
        chk("lub_hold_cnt", 64'(bus.luse_cnt), 64'(exp_cnt));
        bus.mem_busy = 0;
        #1 chk("lub_stall2", 64'(bus.stall_if_id), 64'h1);
        tick(); exp_cnt++;
        chk("lub_bub_valid", 64'(bus.valid_id_ex), 64'h0);
        chk("lub_cnt", 64'(bus.luse_cnt), 64'(exp_cnt));
        tick();
        chk("lub_pc", 64'(bus.pc_id_ex), 64'h404);

        // flush beats load-use and mem_busy
        drive_id(1, 32'h500, 8, 3, 0, 1, 0, 1, 1, 0, 0);
        tick();
        drive_id(1, 32'h504, 9, 8, 0, 1, 0, 1, 0, 0, 0);
        bus.flush_ex = 1;
        #1 chk("fl_stall", 64'(bus.stall_if_id), 64'h0);
        tick();
        chk("fl_valid", 64'(bus.valid_id_ex), 64'h0);
        chk("fl_mr", 64'(bus.MemRead_id_ex), 64'h0);
        chk("fl_cnt", 64'(bus.luse_cnt), 64'(exp_cnt));
        bus.flush_ex = 0;
        drive_id(1, 32'h508, 9, 1, 2, 1, 1, 1, 0, 0, 0);
        tick();
        chk("fl_next_pc", 64'(bus.pc_id_ex), 64'h508);
        bus.flush_ex = 1;
        bus.mem_busy = 1;
        #1 chk("flb_stall", 64'(bus.stall_if_id), 64'h0);
        tick();
        chk("flb_valid", 64'(bus.valid_id_ex), 64'h0);
        chk("flb_wn", 64'(bus.regfile_write_num_id_ex), 64'h0);
        bus.flush_ex = 0;
        bus.mem_busy = 0;

        // WB same-cycle write forwarding
        bus.RegWrite_mem_wb = 1; bus.regfile_write_num_mem_wb = 5; bus.regfile_write_data_wb = 32'hDEADBEEF;
        drive_id(1, 32'h600, 9, 5, 5, 1, 1, 1, 0, 0, 0);
        tick();
        chk("fwd_d1", 64'(bus.regfile_read_data1_id_ex), exp_fwd);
        chk("fwd_d2", 64'(bus.regfile_read_data2_id_ex), exp_fwd);
        bus.regfile_write_num_mem_wb = 0;
        drive_id(1, 32'h604, 9, 0, 0, 1, 1, 1, 0, 32'h77, 32'h88);
        tick();
        chk("fwd_r0_d1", 64'(bus.regfile_read_data1_id_ex), 64'h77);
        chk("fwd_r0_d2", 64'(bus.regfile_read_data2_id_ex), 64'h88);
        bus.RegWrite_mem_wb = 0;

        // drive counter to saturation, then one more event
        while (exp_cnt < SAT) begin
            drive_id(1, 32'h800, 8, 3, 0, 1, 0, 1, 1, 0, 0);
            tick();
            drive_id(1, 32'h804, 9, 8, 0, 1, 0, 1, 0, 0, 0);
            tick();
            exp_cnt++;
        end
        chk("sat_reach", 64'(bus.luse_cnt), 64'(SAT));
        drive_id(1, 32'h800, 8, 3, 0, 1, 0, 1, 1, 0, 0);
        tick();
        drive_id(1, 32'h804, 9, 8, 0, 1, 0, 1, 0, 0, 0);
        #1 chk("sat_stall", 64'(bus.stall_if_id), 64'h1);
        tick();
        chk("sat_hold", 64'(bus.luse_cnt), 64'(SAT));
        chk("sat_bub", 64'(bus.valid_id_ex), 64'h0);

        // async reset in the middle of a load-use stall
        drive_id(1, 32'h700, 8, 3, 0, 1, 0, 1, 1, 32'hAA, 0);
        tick();
        drive_id(1, 32'h704, 9, 8, 0, 1, 0, 1, 0, 0, 0);
        #1 chk("mr_stall", 64'(bus.stall_if_id), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(bus.valid_id_ex), 64'h0);
        chk("mr_pc", 64'(bus.pc_id_ex), 64'h0);
        chk("mr_mr", 64'(bus.MemRead_id_ex), 64'h0);
        chk("mr_d1", 64'(bus.regfile_read_data1_id_ex), 64'h0);
        chk("mr_cnt", 64'(bus.luse_cnt), 64'h0);
        chk("mr_stall_rst", 64'(bus.stall_if_id), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
ID/EX pipeline register with built-in load-use interlock. It captures decoded operands and control from ID and feeds EX, including the forwarding unit's read numbers and read data. A load in EX whose result is needed by the instruction in ID causes a one-cycle stall and a bubble. It also handles memory-busy hold and branch flush.

Parameters:
DATA_W, 32, operand/PC/immediate width
REG_AW, 5, register number width
CTRL_W, 12, opaque pass-through EX/MEM/WB control bits
CNT_W, 16, load-use stall counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
valid_id  in  1  ID holds a real instruction
pc_id, imm_id  in  DATA_W each  PC and sign-extended immediate
ctrl_id  in  CTRL_W  pass-through control bits
RegWrite_id, MemRead_id  in  1 each  writes regfile / is a load
regfile_write_num_id  in  REG_AW  destination register
regfile_read_num1_id, regfile_read_num2_id  in  REG_AW each  rs / rt numbers
uses_rs_id, uses_rt_id  in  1 each  instruction actually reads rs / rt
regfile_read_data1_id, regfile_read_data2_id  in  DATA_W each  regfile read data
RegWrite_mem_wb  in  1  WB stage writes regfile
regfile_write_num_mem_wb  in  REG_AW  WB destination register
regfile_write_data_wb  in  DATA_W  WB write data
mem_busy  in  1  data memory not ready; freeze EX and upstream
flush_ex  in  1  taken branch/jump resolved in EX; squash ID
valid_id_ex  out  1  EX holds a real instruction
pc_id_ex, imm_id_ex, ctrl_id_ex, RegWrite_id_ex, MemRead_id_ex, regfile_write_num_id_ex  out  as inputs  registered copies
regfile_read_num1_id_ex, regfile_read_num2_id_ex  out  REG_AW each  registered source numbers, to bypass
regfile_read_data1_id_ex, regfile_read_data2_id_ex  out  DATA_W each  registered operands, to bypass
stall_if_id  out  1  combinational: hold PC and IF/ID this cycle
luse_cnt  out  CNT_W  count of inserted load-use bubbles

Behaviour:
- Reset (async, rst_n=0): all registered outputs 0, valid_id_ex=0, luse_cnt=0. Takes effect immediately, including mid-stall. stall_if_id=0 while in reset.
- load_use (combinational) = valid_id_ex & MemRead_id_ex & (regfile_write_num_id_ex != 0) & valid_id & ((uses_rs_id & rs==regfile_write_num_id_ex) | (uses_rt_id & rt==regfile_write_num_id_ex)).
- Per-posedge priority, highest first:
  1. flush_ex=1: load a bubble.
  2. mem_busy=1: hold all ID/EX contents unchanged.
  3. load_use=1: load a bubble and increment luse_cnt.
  4. Otherwise: capture all ID inputs; valid_id_ex=valid_id.
- Bubble: valid_id_ex=0, RegWrite_id_ex=0, MemRead_id_ex=0, ctrl_id_ex=0, regfile_write_num_id_ex=0. Data/PC fields are don't-care; implementation zeroes them.
- stall_if_id = !flush_ex & (mem_busy | load_use). Flush never stalls because upstream squashes anyway.
- Load-use stalls exactly one cycle: the bubble clears MemRead_id_ex, so load_use drops on the next cycle.
- Load-use during mem_busy: hold only, no bubble, no count. The stall resolves after mem_busy falls.
- luse_cnt saturates at all-ones and does not wrap.
- Latency: ID inputs appear at outputs one posedge after capture.

Optional Feature:
IDEX_WB_FWD_EN
- Defined: on capture (case 4), if RegWrite_mem_wb & regfile_write_num_mem_wb!=0 & regfile_write_num_mem_wb==regfile_read_num1_id, then regfile_read_data1_id_ex takes regfile_write_data_wb. Same rule for operand 2 with rt. Covers regfile write/read in the same cycle.
- Undefined: regfile data captured unmodified. The WB ports are present but ignored.

Test Plan:
- lw to $8 in EX; ID add with rs=8, uses_rs=1 -> stall_if_id=1 that cycle; next posedge valid_id_ex=0, MemRead_id_ex=0, luse_cnt=1; following cycle stall_if_id=0 and add is captured.
- Same but load destination $0, or uses_rs=0 with rs=8 -> stall_if_id=0, add captured immediately, luse_cnt stays 0.
- ID/EX holds read_data1=0x00001234; mem_busy=1 for 3 cycles with changing ID inputs -> outputs stay 0x00001234, stall_if_id=1 all 3 cycles, then capture resumes.
- flush_ex=1 while load_use=1 -> stall_if_id=0, next state is a bubble, luse_cnt unchanged.
- luse_cnt preset near saturation via 2^CNT_W-1 load-use events -> stays at 0xFFFF after one more event; rst_n pulsed low mid-stall -> all outputs 0 immediately, without waiting for clk.
- With IDEX_WB_FWD_EN: WB writes $5=0xDEADBEEF; ID reads rs=5 with stale regfile data 0x0 -> regfile_read_data1_id_ex=0xDEADBEEF. Without the macro -> 0x0.
